// File: rtl/coin_change_dispenser.sv
// Coin change dispenser: pays a rupee amount out of Rs20/Rs10/Rs5 inventories,
// one coin at a time, over a held-until-ack hopper handshake.
module coin_change_dispenser #(
  parameter int INIT_COUNT = 8,
  parameter int CNT_W      = 6,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [4:0]       req_amount,
  output logic             req_ready,
  output logic             eject_5,
  output logic             eject_10,
  output logic             eject_20,
  input  logic             coin_ack,
  input  logic             refill,
  input  logic [1:0]       refill_sel,
  input  logic [CNT_W-1:0] refill_qty,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_10,
  output logic [CNT_W-1:0] cnt_20,
  output logic             done,
  output logic             short,
  output logic [4:0]       unpaid,
  output logic             fault
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_INIT   = CNT_W'(INIT_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_DONE,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    D_5,
    D_10,
    D_20,
    D_NONE
  } denom_t;

  state_t             state, next_state;
  denom_t             denom, pick;
  logic [4:0]         remaining;
  logic [TIMER_W-1:0] timer;

  // Add refill coins to a counter, clamping at the all-ones maximum.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Rupee value of a denomination code.
  function automatic logic [4:0] denom_value(input denom_t d);
    case (d)
      D_20:    return 5'd20;
      D_10:    return 5'd10;
      D_5:     return 5'd5;
      default: return 5'd0;
    endcase
  endfunction

  // Greedy coin choice, largest denomination that fits and is in stock.
  always_comb begin
    pick = D_NONE;
    if (remaining >= 5'd20 && cnt_20 != '0)
      pick = D_20;
    else if (remaining >= 5'd10 && cnt_10 != '0)
      pick = D_10;
    else if (remaining >= 5'd5 && cnt_5 != '0)
      pick = D_5;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    eject_5    = 1'b0;
    eject_10   = 1'b0;
    eject_20   = 1'b0;
    done       = 1'b0;
    short      = 1'b0;
    fault      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          next_state = S_SELECT;
      end
      S_SELECT: begin
        next_state = (pick != D_NONE) ? S_EJECT : S_DONE;
      end
      S_EJECT: begin
        eject_5  = (denom == D_5);
        eject_10 = (denom == D_10);
        eject_20 = (denom == D_20);
        // An ack on the last allowed cycle still counts as a delivered coin.
        if (coin_ack)
          next_state = S_SELECT;
        else if (timer == TIMER_LAST)
          next_state = S_FAULT;
      end
      S_DONE: begin
        done       = 1'b1;
        short      = (remaining != 5'd0);
        next_state = S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Payout bookkeeping: amount still owed, chosen coin, ack timer, residual.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= 5'd0;
      denom     <= D_NONE;
      timer     <= '0;
      unpaid    <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            remaining <= req_amount;
            unpaid    <= 5'd0;
          end
        end
        S_SELECT: begin
          if (pick != D_NONE) begin
            denom <= pick;
            timer <= '0;
          end else begin
            // Published on entry to DONE so it is valid alongside the done pulse.
            unpaid <= remaining;
          end
        end
        S_EJECT: begin
          if (coin_ack)
            remaining <= remaining - denom_value(denom);
          else if (timer != TIMER_LAST)
            timer <= timer + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Coin inventories: refills only while idle, decrement on each delivered coin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_5  <= CNT_INIT;
      cnt_10 <= CNT_INIT;
      cnt_20 <= CNT_INIT;
    end else if (state == S_IDLE) begin
      if (refill) begin
        case (refill_sel)
          2'd0:    cnt_5  <= sat_add(cnt_5, refill_qty);
          2'd1:    cnt_10 <= sat_add(cnt_10, refill_qty);
          2'd2:    cnt_20 <= sat_add(cnt_20, refill_qty);
          default: ;
        endcase
      end
    end else if (state == S_EJECT && coin_ack) begin
      case (denom)
        D_5:     cnt_5  <= cnt_5 - 1'b1;
        D_10:    cnt_10 <= cnt_10 - 1'b1;
        D_20:    cnt_20 <= cnt_20 - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser: vector table of payouts plus
// hand-written sequences for refill, busy-ignore, timeout and async reset.
module tb_coin_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [4:0] req_amount;
  logic       req_ready;
  logic       eject_5, eject_10, eject_20;
  logic       coin_ack;
  logic       refill;
  logic [1:0] refill_sel;
  logic [5:0] refill_qty;
  logic [5:0] cnt_5, cnt_10, cnt_20;
  logic       done, short;
  logic [4:0] unpaid;
  logic       fault;

  int n_cmp = 0;
  int n_fail = 0;

  coin_change_dispenser #(
    .INIT_COUNT(8),
    .CNT_W(6),
    .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
    .eject_5(eject_5), .eject_10(eject_10), .eject_20(eject_20),
    .coin_ack(coin_ack),
    .refill(refill), .refill_sel(refill_sel), .refill_qty(refill_qty),
    .cnt_5(cnt_5), .cnt_10(cnt_10), .cnt_20(cnt_20),
    .done(done), .short(short), .unpaid(unpaid), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int amount;
    int exp_seq;
    int exp_short;
    int exp_unpaid;
    int exp_c5;
    int exp_c10;
    int exp_c20;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_counts(input string name, input int c5, input int c10, input int c20);
    check({name, " cnt_5"}, int'(cnt_5), c5);
    check({name, " cnt_10"}, int'(cnt_10), c10);
    check({name, " cnt_20"}, int'(cnt_20), c20);
  endtask

  // Issue one request, act as hopper (ack after ack_delay eject cycles, 0 = never),
  // and log the coin sequence as decimal pairs (20,10 -> 2010).
  task automatic run_req(input int amount, input int ack_delay,
                         input bit do_refill, input int rsel, input int rqty,
                         output int seq, output int lat, output int shrt,
                         output int unp, output int to, output int multi);
    int hold;
    int d;
    @(negedge clk);
    req_valid  = 1'b1;
    req_amount = amount[4:0];
    refill     = do_refill;
    refill_sel = rsel[1:0];
    refill_qty = rqty[5:0];
    @(negedge clk);
    req_valid = 1'b0;
    refill    = 1'b0;
    seq = 0; lat = -1; shrt = -1; unp = -1; to = 1; multi = 0; hold = 0;
    for (int i = 1; i <= 300; i++) begin
      coin_ack = 1'b0;
      if (int'(eject_5) + int'(eject_10) + int'(eject_20) > 1) multi++;
      if (done) begin
        if (lat < 0) lat = i;
        shrt = int'(short);
        unp  = int'(unpaid);
        to   = 0;
        break;
      end
      if (eject_5 || eject_10 || eject_20) begin
        if (lat < 0) lat = i;
        d = eject_20 ? 20 : (eject_10 ? 10 : 5);
        if (hold == 0) seq = seq * 100 + d;
        hold++;
        if (hold == ack_delay) coin_ack = 1'b1;
      end else begin
        hold = 0;
      end
      @(negedge clk);
    end
    coin_ack = 1'b0;
  endtask

  task automatic do_refill(input int sel, input int qty);
    @(negedge clk);
    refill     = 1'b1;
    refill_sel = sel[1:0];
    refill_qty = qty[5:0];
    @(negedge clk);
    refill = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq, lat, shrt, unp, to, multi, hi;
    reset = 1'b1; req_valid = 1'b0; req_amount = '0; coin_ack = 1'b0;
    refill = 1'b0; refill_sel = '0; refill_qty = '0;

    vecs[0] = '{30, 2010, 0, 0, 8, 7, 7};
    vecs[1] = '{25, 2005, 0, 0, 7, 7, 6};
    vecs[2] = '{7,  5,    1, 2, 6, 7, 6};
    vecs[3] = '{0,  0,    0, 0, 6, 7, 6};
    vecs[4] = '{31, 2010, 1, 1, 6, 6, 5};
    vecs[5] = '{15, 1005, 0, 0, 5, 5, 5};
    vecs[6] = '{4,  0,    1, 4, 5, 5, 5};

    // Reset state
    #12;
    check_counts("reset", 8, 8, 8);
    check("reset req_ready", int'(req_ready), 1);
    check("reset ejects", int'({eject_5, eject_10, eject_20}), 0);
    check("reset fault", int'(fault), 0);
    check("reset done", int'(done), 0);
    check("reset unpaid", int'(unpaid), 0);
    @(negedge clk);
    reset = 1'b0;

    // coin_ack while idle must not touch inventory
    @(negedge clk); coin_ack = 1'b1;
    @(negedge clk); coin_ack = 1'b0;
    check_counts("idle ack", 8, 8, 8);

    // Vector table: hopper acks 3 cycles into each eject
    for (int v = 0; v < 7; v++) begin
      run_req(vecs[v].amount, 3, 1'b0, 0, 0, seq, lat, shrt, unp, to, multi);
      check($sformatf("v%0d timeout", v), to, 0);
      check($sformatf("v%0d latency", v), lat, 2);
      check($sformatf("v%0d onehot", v), multi, 0);
      check($sformatf("v%0d seq", v), seq, vecs[v].exp_seq);
      check($sformatf("v%0d short", v), shrt, vecs[v].exp_short);
      check($sformatf("v%0d unpaid", v), unp, vecs[v].exp_unpaid);
      @(negedge clk);
      check($sformatf("v%0d done pulse", v), int'(done), 0);
      check($sformatf("v%0d ready", v), int'(req_ready), 1);
      check($sformatf("v%0d unpaid held", v), int'(unpaid), vecs[v].exp_unpaid);
      check_counts($sformatf("v%0d", v), vecs[v].exp_c5, vecs[v].exp_c10, vecs[v].exp_c20);
    end

    // Drain the Rs20 inventory
    for (int k = 0; k < 5; k++) begin
      run_req(20, 1, 1'b0, 0, 0, seq, lat, shrt, unp, to, multi);
      check($sformatf("drain%0d seq", k), seq, 20);
    end
    check("drained cnt_20", int'(cnt_20), 0);

    // 20 owed with no Rs20 coins falls back to two Rs10
    run_req(20, 2, 1'b0, 0, 0, seq, lat, shrt, unp, to, multi);
    check("fallback seq", seq, 1010);
    check("fallback short", shrt, 0);
    check_counts("fallback", 5, 3, 0);

    // Refill in the same cycle as the request is visible to the first SELECT
    run_req(20, 2, 1'b1, 2, 1, seq, lat, shrt, unp, to, multi);
    check("same-cycle refill seq", seq, 20);
    check_counts("same-cycle refill", 5, 3, 0);

    // Refill one Rs20, then 31: 20 + 10, 1 left over
    do_refill(2, 1);
    check("refill20 cnt_20", int'(cnt_20), 1);
    run_req(31, 4, 1'b0, 0, 0, seq, lat, shrt, unp, to, multi);
    check("31 seq", seq, 2010);
    check("31 short", shrt, 1);
    check("31 unpaid", unp, 1);
    check_counts("31", 5, 2, 0);

    // Refill boundaries
    do_refill(0, 63);
    check("sat cnt_5", int'(cnt_5), 63);
    do_refill(3, 5);
    check_counts("sel3", 63, 2, 0);
    do_refill(1, 4);
    check("add cnt_10", int'(cnt_10), 6);

    // Busy: refill and req_valid during EJECT are ignored; async reset drops eject
    @(negedge clk); req_valid = 1'b1; req_amount = 5'd10;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("busy eject_10", int'(eject_10), 1);
    refill = 1'b1; refill_sel = 2'd0; refill_qty = 6'd1;
    req_valid = 1'b1; req_amount = 5'd5;
    @(negedge clk); @(negedge clk);
    refill = 1'b0; req_valid = 1'b0;
    check("busy cnt_5", int'(cnt_5), 63);
    check("busy still eject_10", int'(eject_10), 1);
    check("busy eject_5", int'(eject_5), 0);
    check("busy req_ready", int'(req_ready), 0);
    #2 reset = 1'b1;
    #1;
    check("async eject_10", int'(eject_10), 0);
    check_counts("async reset", 8, 8, 8);
    check("async req_ready", int'(req_ready), 1);
    @(negedge clk); reset = 1'b0;

    // Ack on the final allowed cycle wins over the timeout
    run_req(5, 16, 1'b0, 0, 0, seq, lat, shrt, unp, to, multi);
    check("late ack timeout", to, 0);
    check("late ack seq", seq, 5);
    check("late ack fault", int'(fault), 0);
    check("late ack cnt_5", int'(cnt_5), 7);

    // No ack: eject held exactly 16 cycles, then sticky fault
    @(negedge clk); req_valid = 1'b1; req_amount = 5'd5;
    @(negedge clk); req_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 60 && !fault; i++) begin
      if (eject_5) hi++;
      @(negedge clk);
    end
    check("timeout fault", int'(fault), 1);
    check("timeout eject cycles", hi, 16);
    check("fault eject_5", int'(eject_5), 0);
    check("fault req_ready", int'(req_ready), 0);
    req_valid = 1'b1; req_amount = 5'd20; refill = 1'b1; refill_sel = 2'd1; refill_qty = 6'd3;
    @(negedge clk); @(negedge clk);
    req_valid = 1'b0; refill = 1'b0;
    @(negedge clk);
    check("fault sticky", int'(fault), 1);
    check("fault ejects", int'({eject_5, eject_10, eject_20}), 0);
    check_counts("fault", 7, 8, 8);
    #2 reset = 1'b1;
    #1;
    check("reset clears fault", int'(fault), 0);
    check_counts("post-fault reset", 8, 8, 8);
    check("post-fault req_ready", int'(req_ready), 1);
    @(negedge clk); reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
